lenet_hls_sdiv_seq: RTL and testbench

Sequential signed divider for the Lenet HLS datapath, the inverse of the 12×6→19 signed DSP48 product stage. It takes a 19-bit signed accumulated value and a 6-bit signed scale, and returns a saturated 12-bit quotient plus the remainder, one bit per cycle, behind valid/ready handshakes. It sits after the multiply/accumulate path, where products are rescaled back to activation width.

---
 rtl/lenet_hls_pkg.sv | 22 ++
 rtl/lenet_hls_sdiv_seq_if.sv | 26 ++
 rtl/lenet_hls_sdiv_sat.sv | 47 ++++
 rtl/lenet_hls_sdiv_seq.sv | 141 ++++++++++++++
 tb/tb_lenet_hls_sdiv_seq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/lenet_hls_pkg.sv
// Shared types and constants for the Lenet HLS sequential signed divider.
package lenet_hls_pkg;

  localparam int unsigned DIVIDEND_W = 19;
  localparam int unsigned DIVISOR_W  = 6;
  localparam int unsigned QUOT_W     = 12;
  localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

  // Saturation bounds as QUOT_W-bit codes and as DIVIDEND_W-bit magnitudes
  localparam logic [QUOT_W-1:0]     Q_MAX     = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN     = {1'b1, {(QUOT_W-1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] Q_MAX_MAG = DIVIDEND_W'((2 ** (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] Q_MIN_MAG = DIVIDEND_W'(2 ** (QUOT_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sdiv_state_t;

endpackage

// File: rtl/lenet_hls_sdiv_seq_if.sv
// Operand/result handshake bundle for lenet_hls_sdiv_seq.
interface lenet_hls_sdiv_seq_if;
  import lenet_hls_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  ovf;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, div_by_zero
  );

endinterface

// File: rtl/lenet_hls_sdiv_sat.sv
// Sign-apply and saturate stage for the divider result (combinational).
// Remainder path exists only when LENET_SDIV_REM_EN is defined.
module lenet_hls_sdiv_sat
  import lenet_hls_pkg::*;
(
`ifdef LENET_SDIV_REM_EN
  input  logic [DIVISOR_W-1:0]  rem_mag,
  output logic [DIVISOR_W-1:0]  rem_c,
`endif
  input  logic [DIVIDEND_W-1:0] q_mag,
  input  logic                  neg_q,
  input  logic                  dvd_neg,
  input  logic                  div_zero,
  output logic [QUOT_W-1:0]     quot_c,
  output logic                  ovf_c
);

  always_comb begin
    quot_c = '0;
    ovf_c  = 1'b0;
    if (div_zero) begin
      quot_c = dvd_neg ? Q_MIN : Q_MAX;
      ovf_c  = 1'b1;
    end else if (neg_q) begin
      // Negative side reaches one further than the positive side
      if (q_mag > Q_MIN_MAG) begin
        quot_c = Q_MIN;
        ovf_c  = 1'b1;
      end else begin
        quot_c = QUOT_W'(-q_mag);
      end
    end else if (q_mag > Q_MAX_MAG) begin
      quot_c = Q_MAX;
      ovf_c  = 1'b1;
    end else begin
      quot_c = q_mag[QUOT_W-1:0];
    end
  end

`ifdef LENET_SDIV_REM_EN
  always_comb begin
    rem_c = '0;
    if (!div_zero) rem_c = dvd_neg ? DIVISOR_W'(-rem_mag) : rem_mag;
  end
`endif

endmodule

// File: rtl/lenet_hls_sdiv_seq.sv
// Sequential restoring signed divider, one quotient bit per cycle, saturated 12-bit quotient.
// Build option: LENET_SDIV_REM_EN enables the signed remainder output (else remainder reads 0).
module lenet_hls_sdiv_seq
  import lenet_hls_pkg::*;
(
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  lenet_hls_sdiv_seq_if.slave  bus
);

  sdiv_state_t           r_state;
  logic                  r_load;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd_raw;
  logic [DIVISOR_W-1:0]  r_dvs_raw;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_sgn_dvd;
  logic                  r_sgn_dvs;
  logic                  r_dz;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [QUOT_W-1:0]     r_quot;
  logic                  r_ovf;
  logic                  r_dz_out;

  logic [DIVISOR_W:0]    w_rem_sh;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_rem_nx;
  logic [QUOT_W-1:0]     w_quot;
  logic                  w_ovf;

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign w_rem_sh = {r_rem, r_q[DIVIDEND_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? DIVISOR_W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[DIVISOR_W-1:0];

`ifdef LENET_SDIV_REM_EN
  logic [DIVISOR_W-1:0] r_rem_out;
  logic [DIVISOR_W-1:0] w_rem;
  assign bus.remainder = r_rem_out;
`else
  assign bus.remainder = '0;
`endif

  lenet_hls_sdiv_sat u_sat (
`ifdef LENET_SDIV_REM_EN
    .rem_mag  (r_rem),
    .rem_c    (w_rem),
`endif
    .q_mag    (r_q),
    .neg_q    (r_sgn_dvd ^ r_sgn_dvs),
    .dvd_neg  (r_sgn_dvd),
    .div_zero (r_dz),
    .quot_c   (w_quot),
    .ovf_c    (w_ovf)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= IDLE;
      r_load      <= 1'b0;
      r_cnt       <= '0;
      r_dvd_raw   <= '0;
      r_dvs_raw   <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_sgn_dvd   <= 1'b0;
      r_sgn_dvs   <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_ovf       <= 1'b0;
      r_dz_out    <= 1'b0;
`ifdef LENET_SDIV_REM_EN
      r_rem_out   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_dvd_raw  <= bus.dividend;
            r_dvs_raw  <= bus.divisor;
            r_load     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          if (r_load) begin
            // Magnitudes fit unsigned even for the most-negative operands
            r_load    <= 1'b0;
            r_q       <= r_dvd_raw[DIVIDEND_W-1] ? DIVIDEND_W'(-r_dvd_raw) : r_dvd_raw;
            r_dvs     <= r_dvs_raw[DIVISOR_W-1] ? DIVISOR_W'(-r_dvs_raw) : r_dvs_raw;
            r_sgn_dvd <= r_dvd_raw[DIVIDEND_W-1];
            r_sgn_dvs <= r_dvs_raw[DIVISOR_W-1];
            r_dz      <= (r_dvs_raw == '0);
            r_rem     <= '0;
            r_cnt     <= CNT_W'(DIVIDEND_W - 1);
          end else begin
            r_rem <= w_rem_nx;
            r_q   <= {r_q[DIVIDEND_W-2:0], w_ge};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_state <= FIX;
          end
        end
        FIX: begin
          r_quot      <= w_quot;
          r_ovf       <= w_ovf;
          r_dz_out    <= r_dz;
`ifdef LENET_SDIV_REM_EN
          r_rem_out   <= w_rem;
`endif
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quot;
  assign bus.ovf         = r_ovf;
  assign bus.div_by_zero = r_dz_out;

endmodule

// File: tb/tb_lenet_hls_sdiv_seq.sv
// Scoreboard bench for lenet_hls_sdiv_seq: driver pushes expected results, monitor pops on out_valid.
module tb_lenet_hls_sdiv_seq;
  import lenet_hls_pkg::*;

  typedef struct {
    int q;
    int r;
    int ovf;
    int dz;
    int acc;
  } exp_t;

  localparam int LAT = DIVIDEND_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];

  lenet_hls_sdiv_seq_if bus ();

  lenet_hls_sdiv_seq dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_rem(input int r);
`ifdef LENET_SDIV_REM_EN
    return r;
`else
    return 0 * r;
`endif
  endfunction

  // Drive one operation at a negedge; push the expectation once accepted
  task automatic issue(input int dvd, input int dvs, input int q, input int r,
                       input int ovf, input int dz, input bit push);
    exp_t e;
    int   k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.dividend = DIVIDEND_W'(dvd);
    bus.divisor  = DIVISOR_W'(dvs);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (push) begin
      e.q = q; e.r = exp_rem(r); e.ovf = ovf; e.dz = dz; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'($signed(bus.quotient)), e.q);
        chk("remainder", int'($signed(bus.remainder)), e.r);
        chk("ovf", int'(bus.ovf), e.ovf);
        chk("div_by_zero", int'(bus.div_by_zero), e.dz);
        chk("latency", cyc - e.acc, LAT);
      end
    end
    prev_v = bus.out_valid;
  end

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_remainder", int'(bus.remainder), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_dz", int'(bus.div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: dividend, divisor, quotient, remainder, ovf, dz
    issue(1000, 7, 142, 6, 0, 0, 1);
    issue(-1000, 7, -142, -6, 0, 0, 1);
    issue(1000, -7, -142, 6, 0, 0, 1);
    issue(100000, 3, 2047, 1, 1, 0, 1);
    issue(-262144, -32, 2047, 0, 1, 0, 1);
    issue(5, 0, 2047, 0, 1, 1, 1);
    issue(-5, 0, -2048, 0, 1, 1, 1);
    issue(-24576, 12, -2048, 0, 0, 0, 1);
    issue(24576, 12, 2047, 0, 1, 0, 1);
    issue(-7, 2, -3, -1, 0, 0, 1);
    issue(0, 5, 0, 0, 0, 0, 1);

    // Backpressure: hold result, ignore new operands
    k = 0;
    while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
    bus.out_ready = 1'b0;
    issue(1000, 7, 142, 6, 0, 0, 1);
    k = 0;
    while (!bus.out_valid && k < 60) begin @(negedge clk); k++; end
    chk("bp_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = DIVIDEND_W'(-3);
      bus.divisor  = DIVISOR_W'(1);
      @(negedge clk);
      chk("bp_hold_valid", int'(bus.out_valid), 1);
      chk("bp_hold_quot", int'($signed(bus.quotient)), 142);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    chk("bp_release_out_valid", int'(bus.out_valid), 0);

    // Reset in the middle of CALC discards the operation
    issue(123, 5, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    repeat (30) @(negedge clk);
    issue(1000, 7, 142, 6, 0, 0, 1);

    k = 0;
    while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
